// File: rtl/usb_fifo_pkg.sv
// Shared types for the FX2 slave-FIFO engine.
// FIFOADR codes, FSM states, burst counter width and pin decode.
package usb_fifo_pkg;

  localparam int BCNT_W = 10;

  localparam logic [1:0] EP2_ADR = 2'b00;
  localparam logic [1:0] EP6_ADR = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    RD_OE,
    RD_STROBE,
    RD_WAIT,
    WR_SETUP,
    WR_STROBE,
    WR_WAIT,
    PKTEND,
    TURN
  } state_t;

  typedef struct packed {
    logic [1:0] adr;
    logic       oe;
    logic       sloe_n;
    logic       slrd_n;
    logic       slwr_n;
    logic       pktend_n;
  } pins_t;

  // Pin levels for the state being entered; IDLE/TURN keep FIFOADR.
  function automatic pins_t pins_of(state_t s, logic [1:0] adr);
    pins_t p;
    p.adr      = adr;
    p.oe       = 1'b0;
    p.sloe_n   = 1'b1;
    p.slrd_n   = 1'b1;
    p.slwr_n   = 1'b1;
    p.pktend_n = 1'b1;
    case (s)
      RD_OE: begin
        p.adr    = EP2_ADR;
        p.sloe_n = 1'b0;
      end
      RD_STROBE: begin
        p.adr    = EP2_ADR;
        p.sloe_n = 1'b0;
        p.slrd_n = 1'b0;
      end
      RD_WAIT: begin
        p.adr    = EP2_ADR;
        p.sloe_n = 1'b0;
      end
      WR_SETUP, WR_WAIT: begin
        p.adr = EP6_ADR;
        p.oe  = 1'b1;
      end
      WR_STROBE: begin
        p.adr    = EP6_ADR;
        p.oe     = 1'b1;
        p.slwr_n = 1'b0;
      end
      PKTEND: begin
        p.adr      = EP6_ADR;
        p.oe       = 1'b1;
        p.pktend_n = 1'b0;
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/usb_fifo_skid.sv
// Two-entry ready/valid buffer on the host-to-device path.
// in_free tells the reader there is room for one more strobe.
module usb_fifo_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_free,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_free   = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = mem[rp];
  assign push      = in_valid && in_free;
  assign pop       = out_valid && out_ready;

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/usb_slavefifo_engine.sv
// FX2 slave-FIFO master: EP2 OUT -> OUT stream, IN stream -> EP6.
// Optional counters under `USB_SLAVEFIFO_STATS_EN.
module usb_slavefifo_engine
  import usb_fifo_pkg::*;
#(
  parameter int BURST_MAX = 256
) (
  input  logic        xIFCLK,
  input  logic        RST,
  input  logic [15:0] FD_I,
  output logic [15:0] FD_O,
  output logic        FD_OE,
  output logic [1:0]  FIFOADR,
  output logic        SLRD_N,
  output logic        SLWR_N,
  output logic        SLOE_N,
  output logic        PKTEND_N,
  input  logic        EP2_EMPTY_N,
  input  logic        EP6_FULL_N,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  input  logic [15:0] IN_DATA,
  input  logic        IN_LAST,
  input  logic        IN_VALID,
  output logic        IN_READY
`ifdef USB_SLAVEFIFO_STATS_EN
  ,
  output logic [31:0] STAT_RD_WORDS,
  output logic [31:0] STAT_WR_WORDS,
  output logic [15:0] STAT_PKTENDS
`endif
);

  localparam logic [BCNT_W-1:0] BLIM = BCNT_W'(BURST_MAX - 1);

  state_t            st;
  state_t            nxt;
  pins_t             pins_nxt;
  logic [BCNT_W-1:0] bcnt;
  logic              last_wr;
  logic              last_pend;
  logic              sk_free;
  logic              cap;
  logic              rd_req;
  logic              wr_req;
  logic              done;
  logic              accept;

  assign rd_req   = EP2_EMPTY_N && sk_free;
  assign wr_req   = IN_VALID && EP6_FULL_N;
  assign done     = bcnt >= BLIM;
  assign cap      = st == RD_STROBE;
  assign accept   = wr_req &&
                    (st == WR_SETUP ||
                     (st == WR_WAIT && !last_pend && !done));
  assign IN_READY = accept;
  assign pins_nxt = pins_of(nxt, FIFOADR);

  usb_fifo_skid #(.W(16)) u_skid (
    .clk      (xIFCLK),
    .rst      (RST),
    .in_data  (FD_I),
    .in_valid (cap),
    .in_free  (sk_free),
    .out_data (OUT_DATA),
    .out_valid(OUT_VALID),
    .out_ready(OUT_READY)
  );

  // Next state: round-robin in IDLE, burst continuation in WAIT states.
  always_comb begin
    nxt = st;
    case (st)
      IDLE: begin
        if (rd_req && (!wr_req || last_wr)) nxt = RD_OE;
        else if (wr_req)                    nxt = WR_SETUP;
      end
      RD_OE:     nxt = RD_STROBE;
      RD_STROBE: nxt = RD_WAIT;
      RD_WAIT:   nxt = (rd_req && !done) ? RD_STROBE : TURN;
      WR_SETUP:  nxt = accept ? WR_STROBE : TURN;
      WR_STROBE: nxt = WR_WAIT;
      WR_WAIT: begin
        if (last_pend)   nxt = PKTEND;
        else if (accept) nxt = WR_STROBE;
        else             nxt = TURN;
      end
      PKTEND:  nxt = TURN;
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, registered pins, write data, burst count and arbitration.
  always_ff @(posedge xIFCLK or posedge RST) begin
    if (RST) begin
      st        <= IDLE;
      FD_O      <= 16'h0;
      FIFOADR   <= EP2_ADR;
      FD_OE     <= 1'b0;
      SLOE_N    <= 1'b1;
      SLRD_N    <= 1'b1;
      SLWR_N    <= 1'b1;
      PKTEND_N  <= 1'b1;
      bcnt      <= '0;
      last_wr   <= 1'b1;
      last_pend <= 1'b0;
    end else begin
      st <= nxt;
      {FIFOADR, FD_OE, SLOE_N, SLRD_N, SLWR_N, PKTEND_N} <= pins_nxt;
      if (accept) begin
        FD_O      <= IN_DATA;
        last_pend <= IN_LAST;
      end else if (st == PKTEND) begin
        last_pend <= 1'b0;
      end
      if (nxt == RD_OE || nxt == WR_SETUP) begin
        bcnt <= '0;
      end else if (((st == RD_WAIT && nxt == RD_STROBE) ||
                    (st == WR_WAIT && nxt == WR_STROBE)) &&
                   bcnt != '1) begin
        bcnt <= bcnt + 1'b1;
      end
      if (st == IDLE && nxt == RD_OE)    last_wr <= 1'b0;
      if (st == IDLE && nxt == WR_SETUP) last_wr <= 1'b1;
    end
  end

`ifdef USB_SLAVEFIFO_STATS_EN
  // Wrapping strobe counters.
  always_ff @(posedge xIFCLK or posedge RST) begin
    if (RST) begin
      STAT_RD_WORDS <= '0;
      STAT_WR_WORDS <= '0;
      STAT_PKTENDS  <= '0;
    end else begin
      if (!SLRD_N)   STAT_RD_WORDS <= STAT_RD_WORDS + 1'b1;
      if (!SLWR_N)   STAT_WR_WORDS <= STAT_WR_WORDS + 1'b1;
      if (!PKTEND_N) STAT_PKTENDS  <= STAT_PKTENDS + 1'b1;
    end
  end
`endif

endmodule
